// File: rtl/pi_ctrl_if.sv
// Signal bundle for the PI regulator: run control, setpoint/feedback, gains, output and debug state.
interface pi_ctrl_if;
  logic               en_i;
  logic signed [15:0] ref_i;
  logic signed [15:0] feed_i;
  logic        [31:0] Kp;
  logic        [31:0] Ki;
  logic signed [15:0] out;
  logic        [3:0]  stage;
  logic signed [31:0] e;
  logic signed [31:0] e_p;
  logic signed [31:0] e_i;
  logic signed [41:0] e_int;
  logic signed [41:0] e_int_prev;
  logic        [1:0]  sat_dir;
  logic               accum_e_int;

  modport master (
    output en_i, ref_i, feed_i, Kp, Ki,
    input  out, stage, e, e_p, e_i, e_int, e_int_prev, sat_dir, accum_e_int
  );

  modport slave (
    input  en_i, ref_i, feed_i, Kp, Ki,
    output out, stage, e, e_p, e_i, e_int, e_int_prev, sat_dir, accum_e_int
  );
endinterface

// File: rtl/pi_ctrl.sv
// Fixed-point PI regulator, one update per four-stage pass, with conditional-integration
// anti-windup on the integrator.
module pi_ctrl #(
  parameter int unsigned KP_FRAC   = 16,
  parameter int unsigned KI_FRAC   = 16,
  parameter int unsigned INT_SHIFT = 10,
  parameter int signed   OUT_MAX   = 32767,
  parameter int signed   OUT_MIN   = -32768
) (
  input logic       clk,
  input logic       rst_n,
  pi_ctrl_if.slave  bus
);

  typedef enum logic [3:0] {
    StLatch = 4'd0,
    StMul   = 4'd1,
    StInt   = 4'd2,
    StOut   = 4'd3
  } stage_e;

  localparam logic signed [42:0] IntMax  = (43'sd1 <<< 41) - 43'sd1;
  localparam logic signed [42:0] IntMin  = -(43'sd1 <<< 41);
  localparam logic signed [42:0] OutMaxW = 43'(OUT_MAX);
  localparam logic signed [42:0] OutMinW = 43'(OUT_MIN);

  function automatic logic signed [31:0] sat32(input logic signed [63:0] v);
    if (v > 64'sh0000_0000_7FFF_FFFF) begin
      return 32'sh7FFF_FFFF;
    end else if (v < 64'shFFFF_FFFF_8000_0000) begin
      return 32'sh8000_0000;
    end
    return v[31:0];
  endfunction

  stage_e             stage_q;
  logic signed [31:0] e_q, e_p_q, e_i_q;
  logic signed [41:0] e_int_q, e_int_prev_q;
  logic signed [15:0] out_q;
  logic        [1:0]  sat_q;
  logic               accum_q;

  logic signed [31:0] e_d, e_p_d, e_i_d;
  logic signed [63:0] prod_p, prod_i, shr_p, shr_i;
  logic signed [42:0] int_sum;
  logic signed [41:0] e_int_d, int_sh;
  logic               accum_d;
  logic signed [42:0] out_sum;
  logic signed [15:0] out_d;
  logic        [1:0]  sat_d;

  always_comb begin
    e_d = {{16{bus.ref_i[15]}}, bus.ref_i} - {{16{bus.feed_i[15]}}, bus.feed_i};

    // Gains are unsigned, so zero-extend them before the signed 64-bit product.
    prod_p = {{32{e_q[31]}}, e_q} * {32'd0, bus.Kp};
    prod_i = {{32{e_q[31]}}, e_q} * {32'd0, bus.Ki};
    shr_p  = prod_p >>> KP_FRAC;
    shr_i  = prod_i >>> KI_FRAC;
    e_p_d  = sat32(shr_p);
    e_i_d  = sat32(shr_i);

    // Hold the integrator whenever the increment would push further into the clamp.
    accum_d = !((sat_q == 2'b01 && e_i_q > 32'sd0) || (sat_q == 2'b10 && e_i_q < 32'sd0));
    int_sum = {e_int_q[41], e_int_q} + {{11{e_i_q[31]}}, e_i_q};
    if (!accum_d) begin
      e_int_d = e_int_q;
    end else if (int_sum > IntMax) begin
      e_int_d = IntMax[41:0];
    end else if (int_sum < IntMin) begin
      e_int_d = IntMin[41:0];
    end else begin
      e_int_d = int_sum[41:0];
    end

    int_sh  = e_int_q >>> INT_SHIFT;
    out_sum = {{11{e_p_q[31]}}, e_p_q} + {int_sh[41], int_sh};
    if (out_sum > OutMaxW) begin
      out_d = OutMaxW[15:0];
      sat_d = 2'b01;
    end else if (out_sum < OutMinW) begin
      out_d = OutMinW[15:0];
      sat_d = 2'b10;
    end else begin
      out_d = out_sum[15:0];
      sat_d = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_q      <= StLatch;
      e_q          <= '0;
      e_p_q        <= '0;
      e_i_q        <= '0;
      e_int_q      <= '0;
      e_int_prev_q <= '0;
      out_q        <= '0;
      sat_q        <= '0;
      accum_q      <= 1'b0;
    end else if (!bus.en_i) begin
      stage_q <= StLatch;
    end else begin
      case (stage_q)
        StLatch: begin
          e_q     <= e_d;
          stage_q <= StMul;
        end
        StMul: begin
          e_p_q   <= e_p_d;
          e_i_q   <= e_i_d;
          stage_q <= StInt;
        end
        StInt: begin
          e_int_prev_q <= e_int_q;
          accum_q      <= accum_d;
          e_int_q      <= e_int_d;
          stage_q      <= StOut;
        end
        StOut: begin
          out_q   <= out_d;
          sat_q   <= sat_d;
          stage_q <= StLatch;
        end
        default: stage_q <= StLatch;
      endcase
    end
  end

  assign bus.out         = out_q;
  assign bus.stage       = stage_q;
  assign bus.e           = e_q;
  assign bus.e_p         = e_p_q;
  assign bus.e_i         = e_i_q;
  assign bus.e_int       = e_int_q;
  assign bus.e_int_prev  = e_int_prev_q;
  assign bus.sat_dir     = sat_q;
  assign bus.accum_e_int = accum_q;

endmodule

// File: tb/tb_pi_ctrl.sv
// Bench for pi_ctrl: directed and random updates compared against an arithmetic model of the
// regulator, plus reset, anti-windup, enable-freeze and closed-loop runs.
module tb_pi_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  pi_ctrl_if bus ();

  pi_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Model state, one step per complete update.
  longint m_e, m_ep, m_ei, m_int, m_prev, m_out, m_sat, m_acc;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint clampl(input longint v, input longint lo, input longint hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic model_reset();
    m_e = 0; m_ep = 0; m_ei = 0; m_int = 0; m_prev = 0; m_out = 0; m_sat = 0; m_acc = 0;
  endtask

  task automatic model_update(input longint r, input longint f, input longint kp,
                              input longint ki);
    longint s;
    m_e    = r - f;
    m_ep   = clampl((m_e * kp) >>> 16, -(64'sd1 <<< 31), (64'sd1 <<< 31) - 1);
    m_ei   = clampl((m_e * ki) >>> 16, -(64'sd1 <<< 31), (64'sd1 <<< 31) - 1);
    m_prev = m_int;
    m_acc  = ((m_sat == 1 && m_ei > 0) || (m_sat == 2 && m_ei < 0)) ? 0 : 1;
    if (m_acc == 1) m_int = clampl(m_int + m_ei, -(64'sd1 <<< 41), (64'sd1 <<< 41) - 1);
    s      = m_ep + (m_int >>> 10);
    m_sat  = (s > 32767) ? 1 : (s < -32768) ? 2 : 0;
    m_out  = clampl(s, -32768, 32767);
  endtask

  task automatic check_all();
    check_val("out", bus.out, m_out);
    check_val("e", bus.e, m_e);
    check_val("e_p", bus.e_p, m_ep);
    check_val("e_i", bus.e_i, m_ei);
    check_val("e_int", bus.e_int, m_int);
    check_val("e_int_prev", bus.e_int_prev, m_prev);
    check_val("sat_dir", bus.sat_dir, m_sat);
    check_val("accum", bus.accum_e_int, m_acc);
  endtask

  task automatic drive(input longint r, input longint f, input longint kp, input longint ki);
    bus.ref_i  = 16'(r);
    bus.feed_i = 16'(f);
    bus.Kp     = 32'(kp);
    bus.Ki     = 32'(ki);
  endtask

  // Called at #1 after an edge with the sequencer in stage 0.
  task automatic do_update(input longint r, input longint f, input longint kp, input longint ki);
    drive(r, f, kp, ki);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      check_val("stage_seq", bus.stage, longint'(k % 4));
    end
    model_update(r, f, kp, ki);
    check_all();
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
    model_reset();
    check_val("rst_out", bus.out, 0);
    check_val("rst_stage", bus.stage, 0);
    check_val("rst_e_int", bus.e_int, 0);
    check_val("rst_sat_dir", bus.sat_dir, 0);
    rst_n = 1'b1;
  endtask

  // Drop en_i after two stages: e/e_p/e_i are recomputed on restart, so one model step follows.
  task automatic freeze_mid(input longint r, input longint f, input longint kp, input longint ki);
    drive(r, f, kp, ki);
    repeat (2) @(posedge clk);
    #1;
    bus.en_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("frz_stage", bus.stage, 0);
    check_val("frz_out", bus.out, m_out);
    check_val("frz_e_int", bus.e_int, m_int);
    bus.en_i = 1'b1;
    do_update(r, f, kp, ki);
  endtask

  initial begin
    longint r, f, kp, ki, feed;
    bus.en_i = 1'b1;
    drive(1234, -4321, 65536, 65536);
    model_reset();

    do_reset(5);

    do_update(1000, 0, 65536, 0);
    check_val("p_only_out", bus.out, 1000);
    check_val("p_only_ep", bus.e_p, 1000);

    do_reset(1);
    for (int n = 1; n <= 3; n++) begin
      do_update(10, 0, 0, 64'sd1 <<< 26);
      check_val("i_only_ei", bus.e_i, 10240);
      check_val("i_only_out", bus.out, 10 * n);
    end

    do_reset(1);
    do_update(10000, 0, 262144, 0);
    check_val("sat_hi_out", bus.out, 32767);
    check_val("sat_hi_dir", bus.sat_dir, 1);
    do_update(-10000, 0, 262144, 0);
    check_val("sat_lo_out", bus.out, -32768);
    check_val("sat_lo_dir", bus.sat_dir, 2);

    // Anti-windup: saturated high with positive error must freeze the integrator.
    do_reset(1);
    do_update(10000, 0, 262144, 65536);
    do_update(10000, 0, 262144, 65536);
    check_val("aw_accum", bus.accum_e_int, 0);
    check_val("aw_hold", bus.e_int, bus.e_int_prev);
    do_update(10000, 12000, 262144, 65536);
    check_val("aw_resume", bus.accum_e_int, 1);

    do_reset(1);
    for (int n = 0; n < 60; n++) begin
      r = longint'(shortint'($urandom));
      f = (n % 3 == 0) ? longint'(shortint'($urandom)) : r - longint'($urandom_range(0, 600)) + 300;
      f = clampl(f, -32768, 32767);
      case ($urandom_range(0, 2))
        0:       kp = longint'($urandom_range(0, 1 << 18));
        1:       kp = longint'($urandom_range(0, 1 << 24));
        default: kp = longint'($urandom);
      endcase
      ki = ($urandom_range(0, 3) == 0) ? longint'($urandom) : longint'($urandom_range(0, 1 << 22));
      if (n == 30) freeze_mid(r, f, kp, ki);
      else do_update(r, f, kp, ki);
    end

    // Reset in the middle of an update.
    drive(500, -500, 65536, 65536);
    repeat (2) @(posedge clk);
    #1;
    do_reset(1);

    feed = 0;
    for (int n = 0; n < 200; n++) begin
      if (n == 100) freeze_mid(10000, feed, 50000, 1000000);
      else do_update(10000, feed, 50000, 1000000);
      feed = feed + m_out / 3000;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
